// File: rtl/packet_router_pkg.sv
// Shared types and constants for the packet router core.
// Counter mode is selected by PACKET_ROUTER_COUNTER_SATURATE_EN.
package packet_router_pkg;

  typedef enum logic [1:0] {
    HEAD,
    FWD0,
    FWD1,
    DROP
  } state_t;

  localparam logic [1:0] ROUTE_OUT0 = 2'd0;
  localparam logic [1:0] ROUTE_OUT1 = 2'd1;

  localparam int COUNTER_WIDTH = 32;

  function automatic state_t route_to_state(
    input logic [1:0] route
  );
    state_t s;
    s = DROP;
    if (route == ROUTE_OUT0) s = FWD0;
    if (route == ROUTE_OUT1) s = FWD1;
    return s;
  endfunction

endpackage

// File: rtl/packet_router_if.sv
// AXI-Stream beat bundle used for the router input and both outputs.
// Master drives data/valid/last, slave returns ready.
interface packet_router_if #(
  parameter int DW = 32
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/packet_router_counter.sv
// Statistics counter; wraps by default, saturates when
// PACKET_ROUTER_COUNTER_SATURATE_EN is defined.
module packet_router_counter
  import packet_router_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  output logic [COUNTER_WIDTH-1:0] count
);

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
`ifdef PACKET_ROUTER_COUNTER_SATURATE_EN
      if (count_q != '1)
        count_d = count_q + COUNTER_WIDTH'(1);
`else
      count_d = count_q + COUNTER_WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/packet_router_core.sv
// Zero-latency AXI-Stream 1:2 packet router with drop path and stats.
// Counter mode selected by PACKET_ROUTER_COUNTER_SATURATE_EN.
module packet_router_core
  import packet_router_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  packet_router_if.slave           s_axis,
  packet_router_if.master          m0_axis,
  packet_router_if.master          m1_axis,
  output logic [COUNTER_WIDTH-1:0] num_packets_sent_to_output_0,
  output logic [COUNTER_WIDTH-1:0] num_packets_sent_to_output_1,
  output logic [COUNTER_WIDTH-1:0] num_packets_dropped
);

  state_t state_q;
  state_t state_d;
  state_t path;

  logic s_rdy;
  logic v0;
  logic v1;
  logic acc;
  logic done;
  logic inc0;
  logic inc1;
  logic incd;

  // Header beats pick their path from live tdata; body beats follow state.
  always_comb begin
    path = state_q;
    if (state_q == HEAD)
      path = route_to_state(s_axis.tdata[1:0]);
    s_rdy = 1'b0;
    v0    = 1'b0;
    v1    = 1'b0;
    if (!reset) begin
      unique case (path)
        FWD0: begin
          s_rdy = m0_axis.tready;
          v0    = s_axis.tvalid;
        end
        FWD1: begin
          s_rdy = m1_axis.tready;
          v1    = s_axis.tvalid;
        end
        DROP: s_rdy = 1'b1;
        HEAD: s_rdy = 1'b0;
      endcase
    end
    acc  = s_axis.tvalid & s_rdy;
    done = acc & s_axis.tlast;
    inc0 = done & (path == FWD0);
    inc1 = done & (path == FWD1);
    incd = done & (path == DROP);
    state_d = state_q;
    if (acc)
      state_d = s_axis.tlast ? HEAD : path;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= HEAD;
    else
      state_q <= state_d;
  end

  assign s_axis.tready  = s_rdy;
  assign m0_axis.tvalid = v0;
  assign m1_axis.tvalid = v1;
  assign m0_axis.tdata  = s_axis.tdata[DATA_WIDTH-1:0];
  assign m1_axis.tdata  = s_axis.tdata[DATA_WIDTH-1:0];
  assign m0_axis.tlast  = s_axis.tlast;
  assign m1_axis.tlast  = s_axis.tlast;

  packet_router_counter u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (inc0),
    .count (num_packets_sent_to_output_0)
  );

  packet_router_counter u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (inc1),
    .count (num_packets_sent_to_output_1)
  );

  packet_router_counter u_cntd (
    .clk   (clk),
    .reset (reset),
    .inc   (incd),
    .count (num_packets_dropped)
  );

endmodule

// File: tb/tb_packet_router_core.sv
// Scoreboard bench for packet_router_core.
// Honours PACKET_ROUTER_COUNTER_SATURATE_EN for the wrap check.
module tb_packet_router_core;
  import packet_router_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  packet_router_if #(.DW(32)) s_axis ();
  packet_router_if #(.DW(32)) m0_axis ();
  packet_router_if #(.DW(32)) m1_axis ();

  logic [31:0] n0;
  logic [31:0] n1;
  logic [31:0] nd;

  packet_router_core #(.DATA_WIDTH(32)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .s_axis                       (s_axis),
    .m0_axis                      (m0_axis),
    .m1_axis                      (m1_axis),
    .num_packets_sent_to_output_0 (n0),
    .num_packets_sent_to_output_1 (n1),
    .num_packets_dropped          (nd)
  );

  int checks = 0;
  int failures = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  bit          rdy0_pat[$];
  logic [31:0] exp_cnt[3];
  logic [32:0] e0;
  logic [32:0] e1;
  int          w;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    check({tag, "_out0"}, n0, exp_cnt[0]);
    check({tag, "_out1"}, n1, exp_cnt[1]);
    check({tag, "_drop"}, nd, exp_cnt[2]);
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v);
`ifdef PACKET_ROUTER_COUNTER_SATURATE_EN
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
`else
    return v + 32'd1;
`endif
  endfunction

  // Scoreboard: every handshake on an output must match the next push.
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_axis.tvalid && m0_axis.tready) begin
        if (q0.size() == 0)
          check("m0_unexpected", 64'd1, 64'd0);
        else begin
          e0 = q0.pop_front();
          check("m0_beat", {m0_axis.tlast, m0_axis.tdata}, e0);
        end
      end
      if (m1_axis.tvalid && m1_axis.tready) begin
        if (q1.size() == 0)
          check("m1_unexpected", 64'd1, 64'd0);
        else begin
          e1 = q1.pop_front();
          check("m1_beat", {m1_axis.tlast, m1_axis.tdata}, e1);
        end
      end
    end
  end

  // dest: 0 -> m0, 1 -> m1, 2 -> drop
  task automatic send_beat(input logic [31:0] d,
                           input bit l,
                           input int dest,
                           output int waits);
    logic exp_rdy;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    if (dest == 0) q0.push_back({l, d});
    if (dest == 1) q1.push_back({l, d});
    waits = 0;
    forever begin
      if (rdy0_pat.size() > 0)
        m0_axis.tready = rdy0_pat.pop_front();
      @(negedge clk);
      exp_rdy = (dest == 0) ? m0_axis.tready :
                (dest == 1) ? m1_axis.tready : 1'b1;
      check("m0_valid", m0_axis.tvalid, dest == 0);
      check("m1_valid", m1_axis.tvalid, dest == 1);
      check("s_ready", s_axis.tready, exp_rdy);
      if (l) chk_counts("cnt_pre");
      if (s_axis.tready) break;
      waits++;
      if (waits > 40) begin
        check("hs_timeout", 64'd1, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "handshake timeout");
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (l) begin
      exp_cnt[dest] = bump(exp_cnt[dest]);
      chk_counts("cnt_post");
    end
  endtask

  task automatic idle();
    s_axis.tvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    s_axis.tvalid  = 1'b0;
    s_axis.tdata   = '0;
    s_axis.tlast   = 1'b0;
    m0_axis.tready = 1'b1;
    m1_axis.tready = 1'b1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = '0;

    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_axis.tready, 1'b0);
    check("rst_m0_valid", m0_axis.tvalid, 1'b0);
    check("rst_m1_valid", m1_axis.tvalid, 1'b0);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    reset = 1'b0;
    chk_counts("reset");

    // Three-beat packet to m0
    m1_axis.tready = 1'b0;
    send_beat(32'h0000_0000, 1'b0, 0, w);
    send_beat(32'hDEAD_BE01, 1'b0, 0, w);
    send_beat(32'hCAFE_F002, 1'b1, 0, w);
    idle();

    // Single-beat to m1, then back-to-back single-beat to m0
    m1_axis.tready = 1'b1;
    send_beat(32'h0000_0001, 1'b1, 1, w);
    send_beat(32'h0000_0100, 1'b1, 0, w);
    idle();

    // Four-beat drop with both outputs stalled
    m0_axis.tready = 1'b0;
    m1_axis.tready = 1'b0;
    send_beat(32'h0000_0003, 1'b0, 2, w);
    check("drop_wait0", w, 0);
    send_beat(32'h1111_1110, 1'b0, 2, w);
    check("drop_wait1", w, 0);
    send_beat(32'h2222_2221, 1'b0, 2, w);
    check("drop_wait2", w, 0);
    send_beat(32'h3333_3330, 1'b1, 2, w);
    check("drop_wait3", w, 0);
    idle();

    // m0 backpressure 1,0,0,1
    rdy0_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_beat(32'hC0DE_0010, 1'b0, 0, w);
    check("bp_wait_head", w, 0);
    send_beat(32'hC0DE_0021, 1'b1, 0, w);
    check("bp_wait_last", w, 2);
    idle();

    // Output-0 counter at all-ones, then one more m0 packet
    m0_axis.tready = 1'b1;
    @(negedge clk);
    force dut.u_cnt0.count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.u_cnt0.count_q;
    exp_cnt[0] = 32'hFFFF_FFFF;
    chk_counts("preload");
    send_beat(32'h0000_0004, 1'b1, 0, w);
`ifdef PACKET_ROUTER_COUNTER_SATURATE_EN
    check("sat_hold", n0, 32'hFFFF_FFFF);
`else
    check("wrap_zero", n0, 32'h0000_0000);
`endif
    idle();

    // Reset mid-packet on m1
    m1_axis.tready = 1'b1;
    send_beat(32'h0000_0005, 1'b0, 1, w);
    send_beat(32'hABCD_0000, 1'b0, 1, w);
    s_axis.tdata  = 32'h5555_0001;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_s_ready", s_axis.tready, 1'b0);
    check("mid_rst_m0_valid", m0_axis.tvalid, 1'b0);
    check("mid_rst_m1_valid", m1_axis.tvalid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    s_axis.tvalid = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
    chk_counts("mid_rst");
    check("mid_rst_head", dut.state_q, HEAD);
    send_beat(32'h0000_0008, 1'b1, 0, w);
    idle();

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_router_core.md
# packet_router_core

AXI-Stream packet switch that feeds the router's AXI-Lite statistics register bank. It accepts packets on one slave stream, routes each whole packet to master output 0 or 1 based on a route field in its first beat, and discards packets with an invalid route. It also maintains the three 32-bit statistics counters that the register bank exposes: packets to output 0, packets to output 1, and packets dropped.

## Interface
- DATA_WIDTH, 32: tdata width of all streams; minimum 8.
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  input beat data; bits [1:0] of the first beat are the route field.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last beat of packet.
- m0_axis_tdata / m1_axis_tdata  out  DATA_WIDTH  output data.
- m0_axis_tvalid / m1_axis_tvalid  out  1  output valid.
- m0_axis_tready / m1_axis_tready  in  1  downstream ready.
- m0_axis_tlast / m1_axis_tlast  out  1  last beat.
- num_packets_sent_to_output_0  out  32  completed packets delivered on m0.
- num_packets_sent_to_output_1  out  32  completed packets delivered on m1.
- num_packets_dropped  out  32  completed packets discarded.

## Operation
- Packets are forwarded unmodified. The header beat is forwarded as well.
- Route field on the first beat:
  - 2'd0 → m0
  - 2'd1 → m1
  - 2'd2, 2'd3 → drop
- The FSM is in `packet_router_pkg::state_t`:
  - HEAD: waiting for a first beat. The route is decoded combinationally from the current s_axis_tdata.
  - FWD0 / FWD1: mid-packet on output 0 / 1.
  - DROP: mid-packet discard.
- Transitions:
  - HEAD → FWD0/FWD1/DROP on an accepted first beat with tlast=0.
  - An accepted first beat with tlast=1 (single-beat packet) stays in HEAD.
  - FWDx/DROP → HEAD on an accepted beat with tlast=1.
- Datapath is pure pass-through with no buffering:
  - The selected mX_axis_tvalid equals s_axis_tvalid.
  - s_axis_tready equals the selected mX_axis_tready.
  - The unselected output has tvalid=0.
- In DROP, or in HEAD with an invalid route, s_axis_tready=1 and both tvalid are 0.
- mX_axis_tdata/tlast mirror the s_axis signals at all times; only tvalid is gated.
- Counters increment by 1 on the cycle the tlast beat is accepted (s_axis_tvalid & s_axis_tready & s_axis_tlast) for the path in use. At most one counter increments per cycle.
- Counter width is 32 bits; without the macro they wrap 0xFFFFFFFF → 0.
- Reset:
  - FSM goes to HEAD and all counters go to 0.
  - While reset is high, s_axis_tready=0 and m0/m1_axis_tvalid=0.
  - Reset mid-packet abandons that packet uncounted. Its remaining beats are then parsed as a new header; upstream is responsible for not resetting mid-packet.

## Timing
- Zero-cycle latency from input to output; every input beat appears on its output in the same cycle.
- The route decision and tready are combinational from s_axis_tdata[1:0] and mX_axis_tready.
- Counter outputs are registered and update one cycle after the tlast handshake.
- Backpressure: a stalled output holds the input stalled. No beat is ever lost or duplicated, and tvalid never deasserts without a handshake as long as upstream holds it.

## Configuration
- `PACKET_ROUTER_COUNTER_SATURATE_EN` defined: each counter stops at 0xFFFFFFFF and ignores further increments.
- Undefined: counters wrap modulo 2^32.
- Forwarding behaviour is identical in both builds.

## Structure
- `packet_router_pkg` holds:
  - `state_t` (HEAD, FWD0, FWD1, DROP)
  - route constants ROUTE_OUT0=2'd0 and ROUTE_OUT1=2'd1
  - COUNTER_WIDTH=32
- Sub-module `packet_router_counter` has ports clk, reset, inc, count[31:0]. It implements wrap or saturate per the macro and is instantiated three times.

## Test plan
- Three-beat packet with first beat 0x00000000, m0 tready=1: beats appear on m0 in the same cycles, m1_axis_tvalid stays 0, output-0 count goes 0→1 the cycle after tlast.
- Single-beat packet 0x00000001 with tlast=1: delivered on m1, FSM remains HEAD, output-1 count=1. A back-to-back second packet 0x00000000 is routed to m0 in the next cycle.
- Packet with first beat 0x00000003, 4 beats, both tready=0: all beats accepted in 4 consecutive cycles with no output tvalid; dropped count=1.
- m0 packet with m0_axis_tready toggling 1,0,0,1: s_axis_tready tracks it, beat order is preserved, no beat is duplicated, count=1 only after the tlast handshake.
- Preload/force output-0 count to 0xFFFFFFFF, then send one m0 packet: reads 0x00000000 without the macro and 0xFFFFFFFF with `PACKET_ROUTER_COUNTER_SATURATE_EN`.
- Assert reset for 1 cycle in FWD1 mid-packet: all counts read 0, the FSM is in HEAD, and s_axis_tready=0 during reset.
